rs_syndrome_calc: RTL and testbench
===================================

RS_SYNDROME_CALC -- requirements
Module: rs_syndrome_calc

Interface
REQ-001 SHALL have parameter N_SYM, default 32, meaning codeword length in bytes (32 for C1, 28 for C2); legal range 5..255.
REQ-002 SHALL have parameter PRIM_POLY, default 9'h11D, meaning GF(2^8) field polynomial x^8+x^4+x^3+x^2+1.
REQ-003 SHALL have port clk, input, 1, meaning clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning in_data holds a codeword byte.
REQ-006 SHALL have port in_ready, output, 1, meaning block accepts a byte this cycle.
REQ-007 SHALL have port in_data, input, 8, meaning codeword byte, highest-degree coefficient first.
REQ-008 SHALL have port in_last, input, 1, meaning marks the final byte of a codeword.
REQ-009 SHALL have port syn_valid, output, 1, meaning syndrome set is valid.
REQ-010 SHALL have port syn_ready, input, 1, meaning downstream consumes the syndrome set.
REQ-011 SHALL have port syn_data, output, 32, meaning {S3,S2,S1,S0}, S0 in bits [7:0].
REQ-012 SHALL have port syn_zero, output, 1, meaning S0..S3 all zero (codeword clean).
REQ-013 SHALL have port syn_err, output, 1, meaning codeword length violation.

Function
REQ-014 SHALL accept a byte only on a cycle with in_valid && in_ready.
REQ-015 SHALL compute S_j = sum over i of r_i * alpha^(j*(N_SYM-1-i)), j=0..3, using Horner: S_j <= S_j*alpha^j XOR byte; all additions are XOR.
REQ-016 SHALL load S_j directly with the accepted byte on the first byte of a codeword (no dependency on previous frame).
REQ-017 SHALL keep a byte counter (8 bits) that increments per accepted byte and clears at codeword end.
REQ-018 SHALL implement states IDLE (no bytes yet), ACCUM (1..N_SYM-1 bytes taken), HOLD (result presented).
REQ-019 SHALL transition IDLE->ACCUM on first accepted byte, ACCUM->HOLD on the N_SYM-th accepted byte, HOLD->IDLE on syn_valid && syn_ready.
REQ-020 SHALL assert syn_valid the cycle after the final byte is accepted (latency 1) and hold syn_data, syn_zero, syn_err stable until handshake.
REQ-021 SHALL drive in_ready = 1 in IDLE/ACCUM and 0 in HOLD; a byte offered while in HOLD is not consumed.
REQ-022 SHALL register syn_zero together with syn_data; syn_zero undefined-free (0) whenever syn_valid is 0.

Reset
REQ-023 SHALL on rst_n low force state IDLE, counter 0, syndromes 0, syn_valid 0, syn_zero 0, syn_err 0; in_ready 1 after release.
REQ-024 SHALL discard any partial codeword when reset asserts mid-frame; the next accepted byte starts a new codeword.

Configuration
REQ-025 SHALL compile frame-length checking only when RS_SYN_LEN_CHECK_EN is defined.
REQ-026 SHALL with RS_SYN_LEN_CHECK_EN: close the codeword early on in_last before N_SYM bytes, or on the N_SYM-th byte without in_last, and set syn_err=1 for that result; syn_err=0 when in_last coincides with the N_SYM-th byte.
REQ-027 SHALL without RS_SYN_LEN_CHECK_EN: ignore in_last, close purely by count, tie syn_err to 0.

Structure
REQ-028 SHALL place GF_POLY, the alpha^1..alpha^3 constants and the state enumeration in shared package cd_rs_pkg.
REQ-029 SHALL instantiate the team GF(2^8) multiplier gf256_mult for each of S1..S3 constant multiplies; S0 uses no multiplier.

Verification
REQ-030 SHALL cover: 32 bytes of 0x00 -> syn_data 32'h0, syn_zero 1, syn_valid one cycle after byte 32.
REQ-031 SHALL cover: only byte 31 (last) = 0x05 -> syn_data 32'h05050505, syn_zero 0.
REQ-032 SHALL cover: only byte 30 = 0x01 -> syn_data 32'h08040201.
REQ-033 SHALL cover: syn_ready held low 5 cycles after result -> in_ready 0, syn_data stable, next frame accepted after handshake.
REQ-034 SHALL cover: rst_n pulsed after 10 bytes, then a clean 32-byte all-zero frame -> syn_data 0, syn_zero 1.
REQ-035 SHALL cover (RS_SYN_LEN_CHECK_EN): in_last on byte 20 -> syn_valid next cycle with syn_err 1; next frame with correct in_last -> syn_err 0.

Source files
------------

// File: rtl/cd_rs_pkg.sv
// Shared Reed-Solomon definitions: GF(2^8) field polynomial, the alpha^j
// constants used by the syndrome engine, and the syndrome FSM states.
`timescale 1ns/1ps
package cd_rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;  // x^8+x^4+x^3+x^2+1

  localparam logic [7:0] ALPHA1 = 8'h02;
  localparam logic [7:0] ALPHA2 = 8'h04;
  localparam logic [7:0] ALPHA3 = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } rs_syn_state_t;

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(2^8) multiplier, p = a * b mod PRIM_POLY.
`timescale 1ns/1ps
module gf256_mult
  import cd_rs_pkg::*;
#(
  parameter logic [8:0] PRIM_POLY = GF_POLY
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing as we go.
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? PRIM_POLY[7:0] : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator: S0..S3 over one N_SYM-byte codeword,
// Horner form, result held until downstream handshake.
// Optional macro RS_SYN_LEN_CHECK_EN: close frames on in_last and flag
// length violations on syn_err. Undefined: close by count, syn_err = 0.
//
// state    | meaning
// ST_IDLE  | no byte of the current codeword accepted yet
// ST_ACCUM | 1..N_SYM-1 bytes accepted, syndromes accumulating
// ST_HOLD  | result presented on syn_*, input stalled
`timescale 1ns/1ps
module rs_syndrome_calc
  import cd_rs_pkg::*;
#(
  parameter int         N_SYM     = 32,
  parameter logic [8:0] PRIM_POLY = GF_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        syn_valid,
  input  logic        syn_ready,
  output logic [31:0] syn_data,
  output logic        syn_zero,
  output logic        syn_err
);

  localparam logic [7:0] LAST_CNT = 8'(N_SYM - 1);

  rs_syn_state_t state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] s0, s1, s2, s3;
  logic [7:0] m1, m2, m3;
  logic [7:0] s0_nxt, s1_nxt, s2_nxt, s3_nxt;
  logic       accept, first, cnt_end, close, err_nxt, take_syn;

  gf256_mult #(.PRIM_POLY(PRIM_POLY)) u_mul1 (.a(s1), .b(ALPHA1), .p(m1));
  gf256_mult #(.PRIM_POLY(PRIM_POLY)) u_mul2 (.a(s2), .b(ALPHA2), .p(m2));
  gf256_mult #(.PRIM_POLY(PRIM_POLY)) u_mul3 (.a(s3), .b(ALPHA3), .p(m3));

  assign in_ready  = (state != ST_HOLD);
  assign syn_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign first     = (state == ST_IDLE);
  assign cnt_end   = (cnt == LAST_CNT);
  assign take_syn  = syn_valid && syn_ready;
  assign syn_data  = {s3, s2, s1, s0};

`ifdef RS_SYN_LEN_CHECK_EN
  assign close   = accept && (cnt_end || in_last);
  assign err_nxt = cnt_end ^ in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign close   = accept && cnt_end;
  assign err_nxt = 1'b0;
`endif

  // Horner step; the first byte of a frame loads directly so no stale state leaks in.
  always_comb begin
    s0_nxt = first ? in_data : (s0 ^ in_data);
    s1_nxt = first ? in_data : (m1 ^ in_data);
    s2_nxt = first ? in_data : (m2 ^ in_data);
    s3_nxt = first ? in_data : (m3 ^ in_data);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (close) state_nxt = ST_HOLD;
                else if (accept) state_nxt = ST_ACCUM;
      ST_ACCUM: if (close) state_nxt = ST_HOLD;
      ST_HOLD:  if (take_syn) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Byte counter and syndrome accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'h00;
      s0  <= 8'h00;
      s1  <= 8'h00;
      s2  <= 8'h00;
      s3  <= 8'h00;
    end else if (accept) begin
      cnt <= close ? 8'h00 : cnt + 8'h01;
      s0  <= s0_nxt;
      s1  <= s1_nxt;
      s2  <= s2_nxt;
      s3  <= s3_nxt;
    end
  end

  // Result flags, captured with the closing byte and cleared on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_zero <= 1'b0;
    end else if (close) begin
      syn_zero <= ((s0_nxt | s1_nxt | s2_nxt | s3_nxt) == 8'h00);
    end else if (take_syn) begin
      syn_zero <= 1'b0;
    end
  end

`ifdef RS_SYN_LEN_CHECK_EN
  // Length-violation flag, same capture/clear timing as syn_zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        syn_err <= 1'b0;
    else if (close)    syn_err <= err_nxt;
    else if (take_syn) syn_err <= 1'b0;
  end
`else
  assign syn_err = err_nxt;
`endif

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Directed testbench for rs_syndrome_calc (N_SYM = 32).
`timescale 1ns/1ps
module tb_rs_syndrome_calc;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        syn_valid;
  logic        syn_ready = 1'b0;
  logic [31:0] syn_data;
  logic        syn_zero;
  logic        syn_err;

  logic [7:0]  frame [0:N-1];
  int          checks = 0;
  int          errors = 0;

  rs_syndrome_calc #(.N_SYM(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .syn_valid (syn_valid),
    .syn_ready (syn_ready),
    .syn_data  (syn_data),
    .syn_zero  (syn_zero),
    .syn_err   (syn_err)
  );

  always #5 clk = ~clk;

  task automatic clear_frame();
    for (int i = 0; i < N; i++) frame[i] = 8'h00;
  endtask

  // Feed nbytes of frame[], in_last on index last_at, then check the result.
  task automatic run_frame(input int nbytes, input int last_at, input logic [31:0] exp_data,
                           input logic exp_zero, input logic exp_err, input string name);
    for (int i = 0; i < nbytes; i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == last_at);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready byte %0d: got %b want 1", name, i, in_ready);
      end
      if (i == nbytes - 1) begin
        checks++;
        if (syn_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s early syn_valid: got %b want 0", name, syn_valid);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    checks++;
    if (syn_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s syn_valid latency: got %b want 1", name, syn_valid);
    end
    checks++;
    if (syn_data !== exp_data) begin
      errors++;
      $display("FAIL %s syn_data: got %h want %h", name, syn_data, exp_data);
    end
    checks++;
    if (syn_zero !== exp_zero) begin
      errors++;
      $display("FAIL %s syn_zero: got %b want %b", name, syn_zero, exp_zero);
    end
    checks++;
    if (syn_err !== exp_err) begin
      errors++;
      $display("FAIL %s syn_err: got %b want %b", name, syn_err, exp_err);
    end
  endtask

  task automatic do_handshake(input string name);
    syn_ready = 1'b1;
    @(posedge clk); #1;
    syn_ready = 1'b0;
    checks++;
    if (syn_valid !== 1'b0 || syn_zero !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: got valid=%b zero=%b in_ready=%b want 0 0 1",
               name, syn_valid, syn_zero, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (syn_valid !== 1'b0 || syn_zero !== 1'b0 || syn_err !== 1'b0 || syn_data !== 32'h0) begin
      errors++;
      $display("FAIL reset outputs: got valid=%b zero=%b err=%b data=%h want 0 0 0 0",
               syn_valid, syn_zero, syn_err, syn_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zero_frame();
    clear_frame();
    run_frame(N, N - 1, 32'h0000_0000, 1'b1, 1'b0, "zero_frame");
    do_handshake("zero_frame");
  endtask

  task automatic test_single_byte();
    clear_frame(); frame[31] = 8'h05;
    run_frame(N, N - 1, 32'h0505_0505, 1'b0, 1'b0, "byte31_05");
    do_handshake("byte31_05");
    clear_frame(); frame[30] = 8'h01;
    run_frame(N, N - 1, 32'h0804_0201, 1'b0, 1'b0, "byte30_01");
    do_handshake("byte30_01");
    clear_frame(); frame[29] = 8'h01;
    run_frame(N, N - 1, 32'h4010_0401, 1'b0, 1'b0, "byte29_01");
    do_handshake("byte29_01");
    clear_frame(); frame[27] = 8'h01;
    run_frame(N, N - 1, 32'hCD1D_1001, 1'b0, 1'b0, "byte27_01");
    do_handshake("byte27_01");
    clear_frame(); frame[26] = 8'h01;
    run_frame(N, N - 1, 32'h2674_2001, 1'b0, 1'b0, "byte26_01");
    do_handshake("byte26_01");
  endtask

  // Frames with no idle gap; the second must not depend on the first.
  task automatic test_back_to_back();
    clear_frame(); frame[30] = 8'h01; frame[31] = 8'h05;
    run_frame(N, N - 1, 32'h0D01_0704, 1'b0, 1'b0, "b2b_first");
    do_handshake("b2b_first");
    clear_frame(); frame[31] = 8'h05;
    run_frame(N, N - 1, 32'h0505_0505, 1'b0, 1'b0, "b2b_second");
    do_handshake("b2b_second");
  endtask

  task automatic test_backpressure();
    clear_frame(); frame[30] = 8'h01;
    run_frame(N, N - 1, 32'h0804_0201, 1'b0, 1'b0, "bp_frame");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      in_last  = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || syn_valid !== 1'b1 || syn_data !== 32'h0804_0201) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got in_ready=%b valid=%b data=%h want 0 1 08040201",
                 k, in_ready, syn_valid, syn_data);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    do_handshake("bp_frame");
    clear_frame();
    run_frame(N, N - 1, 32'h0000_0000, 1'b1, 1'b0, "bp_next");
    do_handshake("bp_next");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n = 1'b0;
    #12;
    checks++;
    if (syn_valid !== 1'b0 || syn_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset outputs: got valid=%b data=%h want 0 0", syn_valid, syn_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_frame();
    run_frame(N, N - 1, 32'h0000_0000, 1'b1, 1'b0, "midreset_frame");
    do_handshake("midreset_frame");
  endtask

`ifdef RS_SYN_LEN_CHECK_EN
  task automatic test_len_check();
    clear_frame();
    run_frame(21, 20, 32'h0000_0000, 1'b1, 1'b1, "len_early_last");
    do_handshake("len_early_last");
    clear_frame(); frame[31] = 8'h05;
    run_frame(N, N - 1, 32'h0505_0505, 1'b0, 1'b0, "len_correct");
    do_handshake("len_correct");
    clear_frame(); frame[30] = 8'h01;
    run_frame(N, -1, 32'h0804_0201, 1'b0, 1'b1, "len_missing_last");
    do_handshake("len_missing_last");
  endtask
`else
  task automatic test_len_check();
    clear_frame(); frame[31] = 8'h05;
    run_frame(N, 20, 32'h0505_0505, 1'b0, 1'b0, "last_ignored");
    do_handshake("last_ignored");
  endtask
`endif

  initial begin
    test_reset();
    test_zero_frame();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_len_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
